piggy_report_sched: RTL and testbench

Report scheduler for the piggy-bank datapath. It merges the four coin-counter change pulses and the manual report request into one pending flag. On each report it snapshots the four 3-digit ASCII amounts and streams one fixed-format text frame, byte by byte, into the byte-level UART transmitter. It sits between the counter/num-to-ASCII stage and the UART TX, and replaces the ad-hoc OR-gate start logic with coalescing, hold-off and timeout handling.

---
 rtl/piggy_pkg.sv | 18 +
 rtl/piggy_frame_mux.sv | 36 +++
 rtl/piggy_report_sched.sv | 131 +++++++++++++
 tb/tb_piggy_report_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/piggy_pkg.sv
// piggy_pkg: shared states, frame constants and hex helper for the piggy-bank report scheduler
// Build option: PIGGY_CHECKSUM_EN adds "*HH" before CRLF (24-byte frame instead of 21).
package piggy_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP} state_e;
  localparam logic [7:0] TAG_TEN  = 8'h54;
  localparam logic [7:0] TAG_FIVE = 8'h46;
  localparam logic [7:0] TAG_TWO  = 8'h57;
  localparam logic [7:0] TAG_ONE  = 8'h4F;
  localparam logic [7:0] SP   = 8'h20;
  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;
  localparam logic [7:0] STAR = 8'h2A;
  localparam int FRAME_LEN_BASE = 21;
  localparam int FRAME_LEN_CK   = 24;
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/piggy_frame_mux.sv
// piggy_frame_mux: selects the frame byte at idx from the amount snapshot (and checksum)
// Ports: idx (byte index), snap (4 x 3 ASCII digits), ck (checksum, only with
// PIGGY_CHECKSUM_EN), tx_byte_next (selected byte, 0x00 past the last byte).
module piggy_frame_mux
  import piggy_pkg::*;
(
  input  logic [4:0]  idx,
`ifdef PIGGY_CHECKSUM_EN
  input  logic [7:0]  ck,
`endif
  input  logic [95:0] snap,
  output logic [7:0]  tx_byte_next
);
  localparam logic [31:0] TAGS = {TAG_TEN, TAG_FIVE, TAG_TWO, TAG_ONE};
  logic [7:0] f [32];
  // Four groups of tag, three digits, space; the trailer overwrites the fourth space.
  always_comb begin
    for (int i = 0; i < 32; i++) f[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      f[5*i] = TAGS[31-8*i -: 8];
      for (int j = 0; j < 3; j++) f[5*i+1+j] = snap[95-24*i-8*j -: 8];
      f[5*i+4] = SP;
    end
`ifdef PIGGY_CHECKSUM_EN
    f[19] = STAR;
    f[20] = hex_char(ck[7:4]);
    f[21] = hex_char(ck[3:0]);
    f[22] = CR;
    f[23] = LF;
`else
    f[19] = CR;
    f[20] = LF;
`endif
    tx_byte_next = f[idx];
  end
endmodule

// File: rtl/piggy_report_sched.sv
// piggy_report_sched: coalesces change/report triggers and streams one text frame per report to a UART TX
// Inputs: change_in/report_req triggers, amt_ascii snapshot source, tx_active/tx_done UART handshake.
// Outputs (all registered): tx_dv/tx_byte to UART, busy, frame_done pulse, sticky tx_err.
// Build option: PIGGY_CHECKSUM_EN appends "*HH" (XOR of bytes 0..18) before CRLF.
module piggy_report_sched
  import piggy_pkg::*;
#(
  parameter int GAP_CYCLES = 1000,
  parameter int TX_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  change_in,
  input  logic        report_req,
  input  logic [95:0] amt_ascii,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_err
);
`ifdef PIGGY_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CK;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [4:0] LAST = 5'(FRAME_LEN - 1);
  state_e state_q, state_d;
  logic pending_q, pending_d, fire;
  logic [95:0] snap_q, snap_d;
  logic [4:0] idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d, gap_q, gap_d;
  logic tx_dv_d, busy_d, frame_done_d, tx_err_d;
  logic [7:0] tx_byte_d, byte_nxt;
`ifdef PIGGY_CHECKSUM_EN
  logic [7:0] ck;
  // Tags and the three separating spaces are constant; only the 12 digits vary.
  always_comb begin
    ck = TAG_TEN ^ TAG_FIVE ^ TAG_TWO ^ TAG_ONE ^ SP;
    for (int i = 0; i < 12; i++) ck ^= snap_q[8*i +: 8];
  end
`endif
  // idx_d lets LOAD issue byte 0 (a constant tag) in the same cycle it snapshots.
  piggy_frame_mux u_mux (
    .idx          (idx_d),
`ifdef PIGGY_CHECKSUM_EN
    .ck           (ck),
`endif
    .snap         (snap_q),
    .tx_byte_next (byte_nxt)
  );
  always_comb begin
    state_d      = state_q;
    pending_d    = |change_in | report_req | (pending_q & (state_q != S_LOAD));
    snap_d       = snap_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    tx_byte_d    = tx_byte_q_w();
    tx_dv_d      = 1'b0;
    frame_done_d = 1'b0;
    tx_err_d     = tx_err;
    fire         = 1'b0;
    case (state_q)
      S_IDLE: state_d = pending_q ? S_LOAD : S_IDLE;
      S_LOAD: begin
        snap_d  = amt_ascii;
        idx_d   = 5'd0;
        state_d = S_SEND;
        fire    = !tx_active;
      end
      S_SEND: fire = !tx_active;
      S_WAIT: begin
        if (tx_done) begin
          frame_done_d = (idx_q == LAST);
          idx_d        = (idx_q == LAST) ? idx_q : idx_q + 5'd1;
          gap_d        = 32'd0;
          state_d      = (idx_q == LAST) ? S_GAP : S_SEND;
        end else if (tmo_q >= 32'(TX_TIMEOUT - 1)) begin
          tx_err_d = 1'b1;
          gap_d    = 32'd0;
          state_d  = S_GAP;
        end else tmo_d = tmo_q + 32'd1;
      end
      S_GAP: begin
        state_d = (gap_q >= 32'(GAP_CYCLES - 1)) ? S_IDLE : S_GAP;
        gap_d   = (gap_q >= 32'(GAP_CYCLES - 1)) ? gap_q : gap_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (fire) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = byte_nxt;
      tmo_d     = 32'd0;
      state_d   = S_WAIT;
    end
    busy_d = (state_d != S_IDLE);
  end
  function automatic logic [7:0] tx_byte_q_w();
    return tx_byte;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      snap_q     <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      tx_dv      <= tx_dv_d;
      tx_byte    <= tx_byte_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      tx_err     <= tx_err_d;
    end
  end
endmodule

// File: tb/tb_piggy_report_sched.sv
// tb_piggy_report_sched: directed test of the report scheduler against a 10-cycle UART model
module tb_piggy_report_sched;
  localparam int G = 20;
  localparam int TMO = 200;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] change_in = 4'b0;
  logic report_req = 1'b0;
  logic [95:0] amt_ascii = "012003000105";
  logic tx_active, tx_done;
  logic tx_dv, busy, frame_done, tx_err;
  logic [7:0] tx_byte;
  logic hold = 1'b0, uart_en = 1'b1;
  int ucnt = 0, cyc = 0, fd_cnt = 0, last_fd = 0;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  int dv_cyc[$];
  string e;
  int q0, fd0, t0;
  logic [7:0] ck;

  always #5 clk = ~clk;
  assign tx_active = hold || (ucnt != 0);

  piggy_report_sched #(.GAP_CYCLES(G), .TX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .change_in(change_in), .report_req(report_req),
    .amt_ascii(amt_ascii), .tx_active(tx_active), .tx_done(tx_done),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .busy(busy), .frame_done(frame_done), .tx_err(tx_err)
  );

  // UART model and monitor: 10-cycle bytes, records every byte and frame_done.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (!rst_n) ucnt = 0;
      else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) tx_done = uart_en;
      end else if (tx_dv) ucnt = 10;
      if (tx_dv) begin
        q.push_back(tx_byte);
        dv_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        last_fd = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    step(1);
    report_req = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int n, input int lim);
    for (int i = 0; i < lim && fd_cnt < n; i++) step(1);
    chk(tag, 32'(fd_cnt >= n), 32'd1);
  endtask

  initial begin
    e = "T012 F003 W000 O105";
`ifdef PIGGY_CHECKSUM_EN
    ck = 8'h00;
    for (int i = 0; i < e.len(); i++) ck ^= e[i];
    e = {e, $sformatf("*%02X", ck)};
`else
    ck = 8'h00;
`endif
    e = {e, "\r\n"};
    step(3);
    chk("rst_tx_dv", 32'(tx_dv), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_tx_err", 32'(tx_err), 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_no_dv", 32'(q.size()), 0);
    // Basic report: first byte exactly three cycles after the trigger.
    pulse_req();
    chk("pending_not_busy", 32'(busy), 0);
    step(2);
    chk("first_dv", 32'(tx_dv), 1);
    chk("first_byte", 32'(tx_byte), 32'h54);
    chk("busy_in_frame", 32'(busy), 1);
    amt_ascii = "999999999999";
    wait_fd("fd1_wait", 1, 1000);
    chk("busy_in_gap", 32'(busy), 1);
    step(G + 5);
    chk("idle_after_gap", 32'(busy), 0);
    chk("fd1_count", 32'(fd_cnt), 1);
    chk("frame1_len", 32'(q.size()), 32'(e.len()));
    for (int i = 0; i < e.len() && i < q.size(); i++)
      chk($sformatf("frame1_byte%0d", i), 32'(q[i]), 32'(e[i]));
    // Coalescing: triggers during a frame yield one later frame with fresh values.
    amt_ascii = "111222333444";
    q0 = q.size();
    fd0 = fd_cnt;
    change_in = 4'b0001;
    step(1);
    change_in = 4'b0000;
    step(40);
    amt_ascii = "555666777888";
    change_in = 4'b0100;
    step(1);
    change_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      step(15);
    end
    wait_fd("coal_wait", fd0 + 2, 2000);
    step(G + 60);
    chk("coal_frames", 32'(fd_cnt - fd0), 2);
    chk("coal_bytes", 32'(q.size() - q0), 32'(2 * e.len()));
    chk("coal_f1_d0", 32'(q[q0 + 1]), 32'h31);
    chk("coal_f1_d8", 32'(q[q0 + 18]), 32'h34);
    chk("coal_f2_tag", 32'(q[q0 + e.len()]), 32'h54);
    chk("coal_f2_d0", 32'(q[q0 + e.len() + 1]), 32'h35);
    chk("coal_f2_d8", 32'(q[q0 + e.len() + 18]), 32'h38);
    // Trigger landing exactly on the LOAD cycle keeps pending set.
    amt_ascii = "012003000105";
    q0 = q.size();
    fd0 = fd_cnt;
    pulse_req();
    step(1);
    pulse_req();
    wait_fd("load_trig_wait", fd0 + 1, 1000);
    t0 = last_fd;
    wait_fd("load_trig_wait2", fd0 + 2, 1500);
    step(G + 5);
    chk("load_trig_frames", 32'(fd_cnt - fd0), 2);
    chk("load_trig_bytes", 32'(q.size() - q0), 32'(2 * e.len()));
    chk("gap_to_next_dv", 32'(dv_cyc[q0 + e.len()] - t0), 32'(G + 2));
    // tx_active held high while SEND waits.
    q0 = q.size();
    fd0 = fd_cnt;
    hold = 1'b1;
    pulse_req();
    step(50);
    chk("hold_no_dv", 32'(q.size() - q0), 0);
    chk("hold_busy", 32'(busy), 1);
    hold = 1'b0;
    step(1);
    chk("hold_release_dv", 32'(tx_dv), 1);
    wait_fd("hold_fd_wait", fd0 + 1, 1000);
    step(G + 5);
    // Timeout: UART never reports completion.
    uart_en = 1'b0;
    q0 = q.size();
    fd0 = fd_cnt;
    pulse_req();
    for (int i = 0; i < 10 && q.size() == q0; i++) step(1);
    chk("tmo_first_dv", 32'(q.size() - q0), 1);
    step(195);
    chk("tmo_not_yet", 32'(tx_err), 0);
    step(10);
    chk("tmo_err", 32'(tx_err), 1);
    chk("tmo_no_fd", 32'(fd_cnt - fd0), 0);
    step(G + 5);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_sticky", 32'(tx_err), 1);
    chk("tmo_one_byte", 32'(q.size() - q0), 1);
    uart_en = 1'b1;
    // Asynchronous reset in the middle of byte 7.
    q0 = q.size();
    pulse_req();
    for (int i = 0; i < 200 && q.size() < q0 + 8; i++) step(1);
    chk("rst_reach_byte7", 32'(q.size() - q0), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_dv", 32'(tx_dv), 0);
    chk("arst_tx_byte", 32'(tx_byte), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    chk("arst_tx_err", 32'(tx_err), 0);
    step(2);
    rst_n = 1'b1;
    q0 = q.size();
    step(100);
    chk("arst_no_resume", 32'(q.size() - q0), 0);
    chk("arst_idle", 32'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
